insert_head: RTL and testbench
==============================

INSERT_HEAD -- requirements
Module: insert_head

Interface
REQ-001 Parameter HEAD_WIDTH, default 512, SHALL set the slice data width in bits.
REQ-002 Parameter SHIFT_WIDTH, default 16, SHALL set the insertion granule in bits; HEAD_CANDI_NUM = HEAD_WIDTH/SHIFT_WIDTH (default 32).
REQ-003 Parameter TAG_WIDTH, default 8, SHALL set the per-slice tag width.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 i_clk  input  1  clock; all logic on rising edge.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_head  input  HEAD_WIDTH+TAG_WIDTH  slice; data in [HEAD_WIDTH-1:0] with the first byte at the MSB; tag above it.
REQ-008 o_ready  output  1  upstream may advance i_head this cycle.
REQ-009 i_insData  input  HEAD_WIDTH  bytes to prepend, MSB-aligned; sampled with the start slice.
REQ-010 i_insShift  input  clog2(HEAD_CANDI_NUM)  number of granules to prepend (0..HEAD_CANDI_NUM-1); sampled with the start slice.
REQ-011 o_head  output  HEAD_WIDTH+TAG_WIDTH  registered output slice, same format as i_head.
REQ-012 i_ready  input  1  downstream accepts o_head this cycle.
REQ-013 o_abortCnt  output  16  saturating count of packets aborted by an early start.

Function
REQ-014 A beat SHALL be one slice with TAG_VALID_BIT=1; an input beat is accepted when TAG_VALID_BIT=1 and o_ready=1; an output beat completes when o_head TAG_VALID_BIT=1 and i_ready=1.
REQ-015 A packet SHALL be delimited by TAG_START_BIT on its first slice and TAG_TAIL_BIT on its last; a single slice MAY carry both.
REQ-016 FSM states SHALL be IDLE, BODY and FLUSH.
REQ-017 IDLE: an accepted start slice latches i_insShift (N) and i_insData. The FSM goes to BODY, or to FLUSH if that slice also has tail and N>0.
REQ-018 Output slice 0 SHALL be the top N granules of i_insData followed by the top CANDI-N granules of input slice 0.
REQ-019 Output slice k>0 SHALL be the low N granules carried from input slice k-1 followed by the top CANDI-N granules of input slice k.
REQ-020 When N=0 the block SHALL pass slices unchanged and produce no extra slice.
REQ-021 When N>0, on accepting the tail slice the FSM SHALL enter FLUSH and emit one extra slice: carried granules MSB-aligned, zero-padded, with TAG_VALID_BIT=1 and TAG_TAIL_BIT=1. In this case the output slice built from the input tail slice SHALL have TAG_TAIL_BIT=0.
REQ-022 o_ready SHALL be 0 in FLUSH, and otherwise SHALL equal (~o_head TAG_VALID_BIT | i_ready).
REQ-023 FLUSH SHALL return to IDLE when the extra slice completes.
REQ-024 Latency SHALL be 1 cycle from input acceptance to o_head valid when i_ready=1.
REQ-025 While o_head is valid and i_ready=0, o_head SHALL hold stable.
REQ-026 TAG_START_BIT SHALL appear only on output slice 0. Tag bits other than start, valid and tail SHALL be copied from the input slice that supplies that output slice's upper data.
REQ-027 A start slice accepted in BODY SHALL:
  - discard the carry of the packet in progress;
  - increment o_abortCnt, saturating at 0xFFFF;
  - be processed as a new packet start.
REQ-028 A non-start valid slice accepted in IDLE SHALL be dropped and SHALL NOT change o_abortCnt.
REQ-029 Nothing in this function SHALL apply to slices with TAG_VALID_BIT=0; they SHALL be ignored.

Reset
REQ-030 Under i_rst=1 the block SHALL:
  - set o_head to all zeros;
  - clear the carry and the latched N;
  - set o_abortCnt to 0 and the FSM to IDLE.
REQ-031 The reset values SHALL be visible on the cycle after i_rst is sampled high, in any state including mid-FLUSH; an in-flight packet is lost.
REQ-032 o_ready SHALL be 0 while i_rst=1.

Structure
REQ-033 The following SHALL live in the shared parser package:
  - TAG_START_BIT, TAG_VALID_BIT, TAG_TAIL_BIT positions;
  - HEAD_WIDTH, SHIFT_WIDTH and TAG_WIDTH defaults;
  - the FSM state enum.
REQ-034 The granule concatenate-and-select logic SHALL be one combinational sub-module, head_merge. It takes {prefix, slice} and N, and returns merged data and the next carry.

Verification (HEAD_WIDTH=512, SHIFT_WIDTH=16)
REQ-035 N=0, 3-slice packet, i_ready=1 -> 3 identical slices, each 1 cycle after acceptance; o_ready never drops.
REQ-036 N=4, i_insData top 8 bytes 0xA0..0xA7, 2-slice packet ->
  - 3 slices: slice0 = A0..A7 followed by the first 56 bytes of input slice 0;
  - slice2 = last 8 bytes of input slice 1 followed by 56 zero bytes, tail bit set;
  - o_ready low exactly one cycle.
REQ-037 N=31, single slice with start+tail -> 2 slices: first with start only, second with tail only; then IDLE.
REQ-038 i_ready held low for 5 cycles mid-packet with N=3 -> o_head stable throughout, no slice lost or duplicated, o_ready tracks REQ-022.
REQ-039 Start arriving in BODY -> o_abortCnt=1; the new packet is output correctly. Non-start slice in IDLE -> dropped, count unchanged.
REQ-040 i_rst=1 during FLUSH -> next cycle o_head=0, o_abortCnt=0, FSM IDLE; the following packet is correct.

Source files
------------

// File: rtl/insert_head_pkg.sv
// rtl/insert_head_pkg.sv - shared parser definitions: tag bit positions, width defaults, FSM states
package insert_head_pkg;

  localparam int HEAD_WIDTH_DEF  = 512;
  localparam int SHIFT_WIDTH_DEF = 16;
  localparam int TAG_WIDTH_DEF   = 8;

  // Bit positions inside the tag field, which sits directly above the data.
  localparam int TAG_VALID_BIT = 0;
  localparam int TAG_START_BIT = 1;
  localparam int TAG_TAIL_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/head_merge.sv
// rtl/head_merge.sv - granule concatenate-and-select: merged slice and next carry from {prefix, slice}
module head_merge
  import insert_head_pkg::*;
#(
  parameter int HEAD_WIDTH  = HEAD_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  parameter int SHIFT_BITS  = $clog2(HEAD_WIDTH / SHIFT_WIDTH)
) (
  input  logic [2*HEAD_WIDTH-1:0] cat_i,
  input  logic [SHIFT_BITS-1:0]   shift_i,
  output logic [HEAD_WIDTH-1:0]   merged_o,
  output logic [HEAD_WIDTH-1:0]   carry_o
);

  // The prefix holds its N live granules in its low end, so one right shift
  // lines them up directly ahead of the top CANDI-N granules of the slice.
  always_comb begin
    merged_o = HEAD_WIDTH'(cat_i >> (int'(shift_i) * SHIFT_WIDTH));
    carry_o  = cat_i[HEAD_WIDTH-1:0] & ~({HEAD_WIDTH{1'b1}} << (int'(shift_i) * SHIFT_WIDTH));
  end

endmodule

// File: rtl/insert_head.sv
// rtl/insert_head.sv - prepends N granules of header bytes to a sliced packet stream
module insert_head
  import insert_head_pkg::*;
#(
  parameter int HEAD_WIDTH  = HEAD_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  parameter int TAG_WIDTH   = TAG_WIDTH_DEF
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0]             i_head,
  output logic                                        o_ready,
  input  logic [HEAD_WIDTH-1:0]                       i_insData,
  input  logic [$clog2(HEAD_WIDTH/SHIFT_WIDTH)-1:0]   i_insShift,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]             o_head,
  input  logic                                        i_ready,
  output logic [15:0]                                 o_abortCnt
);

  localparam int HEAD_CANDI_NUM = HEAD_WIDTH / SHIFT_WIDTH;
  localparam int SHIFT_BITS     = $clog2(HEAD_CANDI_NUM);

  state_e                          state_q, state_d;
  logic [SHIFT_BITS-1:0]           shift_q, shift_d;
  logic [HEAD_WIDTH-1:0]           carry_q, carry_d;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_q, head_d;
  logic [15:0]                     abort_q, abort_d;

  logic [TAG_WIDTH-1:0]  in_tag, out_tag, flush_tag;
  logic [HEAD_WIDTH-1:0] in_data, ins_aligned;
  logic                  in_valid, in_start, in_tail;
  logic                  out_valid, slot_free, accept, take_start, take_body;
  logic [SHIFT_BITS-1:0] mrg_shift;
  logic [HEAD_WIDTH-1:0] mrg_prefix, mrg_slice, mrg_data, mrg_carry;

  assign in_tag    = i_head[HEAD_WIDTH+TAG_WIDTH-1:HEAD_WIDTH];
  assign in_data   = i_head[HEAD_WIDTH-1:0];
  assign in_valid  = in_tag[TAG_VALID_BIT];
  assign in_start  = in_tag[TAG_START_BIT];
  assign in_tail   = in_tag[TAG_TAIL_BIT];
  assign out_valid = head_q[HEAD_WIDTH+TAG_VALID_BIT];
  assign slot_free = ~out_valid | i_ready;

  assign o_ready    = ~i_rst & (state_q != FLUSH) & slot_free;
  assign accept     = in_valid & o_ready;
  assign take_start = accept & in_start;
  assign take_body  = accept & ~in_start & (state_q == BODY);

  // Move the top N insert granules to the low end so they act like a carry.
  assign ins_aligned = i_insData >> ((HEAD_CANDI_NUM - int'(i_insShift)) * SHIFT_WIDTH);

  always_comb begin
    mrg_shift  = shift_q;
    mrg_prefix = carry_q;
    mrg_slice  = in_data;
    if (state_q == FLUSH) begin
      mrg_slice = '0;
    end
    if (take_start) begin
      mrg_shift  = i_insShift;
      mrg_prefix = ins_aligned;
    end
  end

  head_merge #(
    .HEAD_WIDTH  (HEAD_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH),
    .SHIFT_BITS  (SHIFT_BITS)
  ) u_merge (
    .cat_i    ({mrg_prefix, mrg_slice}),
    .shift_i  (mrg_shift),
    .merged_o (mrg_data),
    .carry_o  (mrg_carry)
  );

  always_comb begin
    out_tag                = in_tag;
    out_tag[TAG_VALID_BIT] = 1'b1;
    out_tag[TAG_START_BIT] = take_start;
    out_tag[TAG_TAIL_BIT]  = in_tail & (mrg_shift == '0);
    flush_tag                = '0;
    flush_tag[TAG_VALID_BIT] = 1'b1;
    flush_tag[TAG_TAIL_BIT]  = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    carry_d = carry_q;
    abort_d = abort_q;
    head_d  = head_q;
    if (out_valid & i_ready) begin
      head_d = '0;
    end
    if (take_start | take_body) begin
      head_d  = {out_tag, mrg_data};
      carry_d = mrg_carry;
      shift_d = mrg_shift;
      if (take_start && (state_q == BODY) && (abort_q != 16'hFFFF)) begin
        abort_d = abort_q + 16'd1;
      end
      if (in_tail) begin
        state_d = (mrg_shift != '0) ? FLUSH : IDLE;
      end else begin
        state_d = BODY;
      end
    end else if ((state_q == FLUSH) && slot_free) begin
      // Extra slice goes out; from here on normal IDLE handshaking retires it.
      head_d  = {flush_tag, mrg_data};
      carry_d = '0;
      shift_d = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      carry_q <= '0;
      abort_q <= '0;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      carry_q <= carry_d;
      abort_q <= abort_d;
      head_q  <= head_d;
    end
  end

  assign o_head     = head_q;
  assign o_abortCnt = abort_q;

endmodule

// File: tb/tb_insert_head.sv
// tb/tb_insert_head.sv - self-checking bench for insert_head against a granule-stream model
module tb_insert_head;
  import insert_head_pkg::*;

  localparam int HW    = 512;
  localparam int SW    = 16;
  localparam int TW    = 8;
  localparam int CANDI = HW / SW;
  localparam int NB    = $clog2(CANDI);

  logic             clk = 1'b0;
  logic             rst;
  logic [HW+TW-1:0] i_head;
  logic [HW+TW-1:0] o_head;
  logic             o_ready;
  logic             i_ready;
  logic [HW-1:0]    ins;
  logic [NB-1:0]    shift;
  logic [15:0]      abort_cnt;

  always #5 clk = ~clk;

  insert_head #(.HEAD_WIDTH(HW), .SHIFT_WIDTH(SW), .TAG_WIDTH(TW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_head     (i_head),
    .o_ready    (o_ready),
    .i_insData  (ins),
    .i_insShift (shift),
    .o_head     (o_head),
    .i_ready    (i_ready),
    .o_abortCnt (abort_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [HW+TW-1:0] exp_q[$];
  logic [SW-1:0]    stream[$];
  bit               in_pkt = 0;
  int               slice_idx = 0;
  int               m_n = 0;
  int               m_abort = 0;
  int               rdy_pct = 100;
  int               ready_low_cnt = 0;
  int               out_cnt = 0;

  task automatic chk(input string name, input logic [HW+TW-1:0] obs, input logic [HW+TW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [HW-1:0] rnd_data();
    logic [HW-1:0] v;
    for (int i = 0; i < HW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [SW-1:0] gran(input logic [HW-1:0] v, input int g);
    return v[HW-1-g*SW -: SW];
  endfunction

  function automatic logic [HW-1:0] pop_slice();
    logic [HW-1:0] s;
    s = '0;
    for (int g = 0; g < CANDI; g++)
      if (stream.size() > 0) s[HW-1-g*SW -: SW] = stream.pop_front();
    return s;
  endfunction

  // Packet view: output = insert granules ++ all input granules, re-sliced.
  task automatic model_accept(input logic [HW-1:0] d, input logic [TW-1:0] tag,
                              input logic [HW-1:0] insd, input int n);
    logic [TW-1:0] et;
    logic [HW-1:0] s;
    if (tag[TAG_START_BIT]) begin
      if (in_pkt) m_abort = (m_abort == 65535) ? 65535 : m_abort + 1;
      stream.delete();
      m_n = n;
      for (int g = 0; g < n; g++) stream.push_back(gran(insd, g));
      in_pkt = 1;
      slice_idx = 0;
    end else if (!in_pkt) begin
      return;
    end
    for (int g = 0; g < CANDI; g++) stream.push_back(gran(d, g));
    s = pop_slice();
    et = tag;
    et[TAG_VALID_BIT] = 1'b1;
    et[TAG_START_BIT] = (slice_idx == 0);
    et[TAG_TAIL_BIT]  = tag[TAG_TAIL_BIT] && (m_n == 0);
    exp_q.push_back({et, s});
    slice_idx++;
    if (tag[TAG_TAIL_BIT]) begin
      if (m_n > 0) begin
        s = pop_slice();
        et = '0;
        et[TAG_VALID_BIT] = 1'b1;
        et[TAG_TAIL_BIT]  = 1'b1;
        exp_q.push_back({et, s});
      end
      in_pkt = 0;
      stream.delete();
    end
  endtask

  function automatic logic pick_ready();
    return ($urandom_range(99) < rdy_pct);
  endfunction

  task automatic send(input logic [HW-1:0] d, input logic [TW-1:0] tag,
                      input logic [HW-1:0] insd, input int n);
    bit done;
    done = 0;
    for (int w = 0; w < 300 && !done; w++) begin
      @(posedge clk); #1;
      i_head  = {tag, d};
      ins     = insd;
      shift   = NB'(n);
      i_ready = pick_ready();
      @(negedge clk);
      if (o_ready) begin
        if (tag[TAG_VALID_BIT]) model_accept(d, tag, insd, n);
        done = 1;
      end
    end
    chk("send_accept_timeout", done, 1'b1);
  endtask

  task automatic idle(input int n);
    logic [TW-1:0] t;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      t = TW'($urandom);
      t[TAG_VALID_BIT] = 1'b0;
      i_head  = {t, rnd_data()};
      ins     = rnd_data();
      shift   = NB'($urandom);
      i_ready = pick_ready();
    end
  endtask

  function automatic logic [TW-1:0] mk_tag(input bit s, input bit t);
    logic [TW-1:0] v;
    v = TW'($urandom);
    v[TAG_VALID_BIT] = 1'b1;
    v[TAG_START_BIT] = s;
    v[TAG_TAIL_BIT]  = t;
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    i_head = '0;
    i_ready = 1'b0;
    @(negedge clk);
    chk("ready_in_reset", o_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    stream.delete();
    in_pkt = 0;
    m_abort = 0;
    @(negedge clk);
    chk("reset_head", o_head, '0);
    chk("reset_abort", abort_cnt, 16'd0);
  endtask

  logic [HW+TW-1:0] prev_head;
  bit               prev_hold = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 0;
    end else begin
      if (!o_ready) ready_low_cnt++;
      if (prev_hold) chk("hold_stable", o_head, prev_head);
      if (o_head[HW+TAG_VALID_BIT]) begin
        if (!i_ready) begin
          chk("ready_backpressure", o_ready, 1'b0);
        end else begin
          out_cnt++;
          if (exp_q.size() == 0) chk("unexpected_slice", 1'b1, 1'b0);
          else chk("out_slice", o_head, exp_q.pop_front());
        end
      end
      prev_hold = o_head[HW+TAG_VALID_BIT] && !i_ready;
      prev_head = o_head;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            oc;
    int            n;
    int            len;
    bit            cut;
    logic [HW-1:0] insd;

    rst = 1'b1;
    i_head = '0;
    i_ready = 1'b0;
    ins = '0;
    shift = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_head", o_head, '0);
    chk("init_abort", abort_cnt, 16'd0);
    chk("init_ready", o_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // N=0 passthrough, ready always high
    rdy_pct = 100;
    idle(1);
    ready_low_cnt = 0;
    oc = out_cnt;
    insd = rnd_data();
    send(rnd_data(), mk_tag(1, 0), insd, 0);
    send(rnd_data(), mk_tag(0, 0), insd, 0);
    send(rnd_data(), mk_tag(0, 1), insd, 0);
    idle(4);
    chk("n0_ready_low", ready_low_cnt, 0);
    chk("n0_slice_count", out_cnt - oc, 3);

    // N=4 with A0..A7 header, 2-slice packet
    insd = rnd_data();
    insd[HW-1 -: 64] = 64'hA0A1_A2A3_A4A5_A6A7;
    ready_low_cnt = 0;
    oc = out_cnt;
    send(rnd_data(), mk_tag(1, 0), insd, 4);
    send(rnd_data(), mk_tag(0, 1), insd, 4);
    idle(4);
    chk("n4_ready_low", ready_low_cnt, 1);
    chk("n4_slice_count", out_cnt - oc, 3);

    // N=31 single start+tail slice
    ready_low_cnt = 0;
    oc = out_cnt;
    send(rnd_data(), mk_tag(1, 1), rnd_data(), 31);
    idle(4);
    chk("n31_ready_low", ready_low_cnt, 1);
    chk("n31_slice_count", out_cnt - oc, 2);

    // N=3 with a 5-cycle downstream stall mid-packet
    oc = out_cnt;
    insd = rnd_data();
    send(rnd_data(), mk_tag(1, 0), insd, 3);
    send(rnd_data(), mk_tag(0, 0), insd, 3);
    rdy_pct = 0;
    idle(5);
    rdy_pct = 100;
    send(rnd_data(), mk_tag(0, 1), insd, 3);
    idle(4);
    chk("stall_slice_count", out_cnt - oc, 4);

    // start inside a packet aborts it; stray body slice in IDLE is dropped
    send(rnd_data(), mk_tag(1, 0), rnd_data(), 2);
    send(rnd_data(), mk_tag(0, 0), rnd_data(), 2);
    send(rnd_data(), mk_tag(1, 0), rnd_data(), 5);
    send(rnd_data(), mk_tag(0, 1), rnd_data(), 5);
    idle(4);
    chk("abort_count_one", abort_cnt, 16'd1);
    oc = out_cnt;
    send(rnd_data(), mk_tag(0, 0), rnd_data(), 6);
    idle(4);
    chk("stray_dropped", out_cnt - oc, 0);
    chk("stray_abort_same", abort_cnt, 16'd1);

    // reset while FLUSH holds the tail slice
    rdy_pct = 0;
    send(rnd_data(), mk_tag(1, 1), rnd_data(), 5);
    idle(1);
    do_reset();
    rdy_pct = 100;
    oc = out_cnt;
    insd = rnd_data();
    send(rnd_data(), mk_tag(1, 0), insd, 7);
    send(rnd_data(), mk_tag(0, 1), insd, 7);
    idle(4);
    chk("post_reset_count", out_cnt - oc, 3);

    // randomized packets, gaps, backpressure, aborts and strays
    rdy_pct = 70;
    for (int p = 0; p < 40; p++) begin
      case ($urandom_range(3))
        0:       n = 0;
        1:       n = CANDI - 1;
        default: n = $urandom_range(CANDI - 1);
      endcase
      len  = $urandom_range(1, 4);
      cut  = ($urandom_range(99) < 15) && (len > 1);
      insd = rnd_data();
      if ($urandom_range(99) < 20) send(rnd_data(), mk_tag(0, $urandom_range(1)), rnd_data(), n);
      for (int i = 0; i < len; i++) begin
        if (cut && i == len - 1) break;
        send(rnd_data(), mk_tag(i == 0, i == len - 1), insd, n);
        idle($urandom_range(2));
      end
    end
    rdy_pct = 100;
    idle(20);
    chk("queue_drained", exp_q.size(), 0);
    chk("abort_final", abort_cnt, 16'(m_abort));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
